systolic_host_link: RTL

//  Host-side partner of the systolic tile's 16-beat nibble-serial link.
//  - Serialises one command per block onto the tile's column and row inputs (4-bit data + 1 ctrl bit per beat).
//  - Deserialises the frame the tile echoes back one block later and presents it as a parallel response.
//  - Sits between a host/test controller and the tile ui_in/uio pins; its beat counter runs in lockstep with the tile's.

---
 rtl/systolic_host_link.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_host_link.sv
// Host-side partner of the systolic tile's 16-beat nibble-serial link: serialises one
// command per block onto the tile inputs and deserialises the frame echoed one block later.

module systolic_host_link_lane (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [63:0] load_data,
   output logic [3:0]  nib,
   input  logic [3:0]  ret_nib,
   output logic [63:0] rx_frame
);
   logic [59:0] tx_sh;
   logic [59:0] rx_sh;

   // The nibble arriving this cycle completes the frame, so the top can capture it in one step.
   assign rx_frame = {rx_sh, ret_nib};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sh <= '0;
         nib   <= '0;
         rx_sh <= '0;
      end else begin
         if (load) begin
            nib   <= load_data[63:60];
            tx_sh <= load_data[59:0];
         end else begin
            nib   <= tx_sh[59:56];
            tx_sh <= {tx_sh[55:0], 4'h0};
         end
         rx_sh <= rx_frame[59:0];
      end
   end
endmodule

module systolic_host_link (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_addr,
   input  logic        cmd_write,
   input  logic [63:0] cmd_col_data,
   input  logic [63:0] cmd_row_data,
   output logic [3:0]  col_nib,
   output logic        col_ctrl,
   output logic [3:0]  row_nib,
   output logic        row_ctrl,
   input  logic [3:0]  col_ret_nib,
   input  logic        col_ret_ctrl,
   input  logic [3:0]  row_ret_nib,
   input  logic        row_ret_ctrl,
   output logic [3:0]  beat,
   output logic        rsp_valid,
   output logic [63:0] rsp_col_data,
   output logic [15:0] rsp_col_ctrl,
   output logic [63:0] rsp_row_data
);
   localparam int NUM_LANES = 2;

   typedef struct packed {
      logic [63:0] col;
      logic [63:0] row;
      logic [15:0] ctrl;
   } frame_t;

   logic                       blk_end;
   logic                       accept;
   logic                       pend_full;
   frame_t                     pend;
   frame_t                     cmd_frame;
   frame_t                     src;
   logic                       src_tag;
   logic [1:0]                 vld_pipe;
   logic [14:0]                tx_ctrl_sh;
   logic [14:0]                rx_ctrl_sh;
   logic [15:0]                rx_ctrl_frame;
   logic [NUM_LANES-1:0][63:0] lane_load;
   logic [NUM_LANES-1:0][63:0] lane_rx;
   logic [NUM_LANES-1:0][3:0]  lane_nib;
   logic [NUM_LANES-1:0][3:0]  lane_ret;
   logic                       unused_row_ret_ctrl;

   assign unused_row_ret_ctrl = row_ret_ctrl;

   assign blk_end   = (beat == 4'hF);
   assign cmd_ready = !pend_full | blk_end;
   assign accept    = cmd_valid & cmd_ready;
   assign cmd_frame = {cmd_col_data, cmd_row_data, cmd_addr, 2'b00, cmd_write, 5'b00000};

   // Frame launched at the block boundary: pending entry first, otherwise a command
   // accepted on this very beat bypasses pend, otherwise an untagged idle frame.
   always_comb begin
      src     = '0;
      src_tag = 1'b0;
      if (pend_full) begin
         src     = pend;
         src_tag = 1'b1;
      end else if (accept) begin
         src     = cmd_frame;
         src_tag = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat      <= '0;
         pend_full <= 1'b0;
         pend      <= '0;
      end else begin
         beat <= beat + 4'd1;
         if (blk_end) begin
            pend_full <= pend_full & accept;
            if (pend_full & accept)
               pend <= cmd_frame;
         end else if (accept) begin
            pend_full <= 1'b1;
            pend      <= cmd_frame;
         end
      end
   end

   assign rx_ctrl_frame = {rx_ctrl_sh, col_ret_ctrl};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_ctrl     <= 1'b0;
         tx_ctrl_sh   <= '0;
         rx_ctrl_sh   <= '0;
         vld_pipe     <= '0;
         rsp_valid    <= 1'b0;
         rsp_col_data <= '0;
         rsp_col_ctrl <= '0;
         rsp_row_data <= '0;
      end else begin
         rx_ctrl_sh <= rx_ctrl_frame[14:0];
         rsp_valid  <= 1'b0;
         if (blk_end) begin
            col_ctrl   <= src.ctrl[15];
            tx_ctrl_sh <= src.ctrl[14:0];
            // Stage 0: frame on the wire next block; stage 1: its echo arriving.
            vld_pipe   <= {vld_pipe[0], src_tag};
            if (vld_pipe[1]) begin
               rsp_valid    <= 1'b1;
               rsp_col_data <= lane_rx[0];
               rsp_row_data <= lane_rx[1];
               rsp_col_ctrl <= rx_ctrl_frame;
            end
         end else begin
            col_ctrl   <= tx_ctrl_sh[14];
            tx_ctrl_sh <= {tx_ctrl_sh[13:0], 1'b0};
         end
      end
   end

   assign row_ctrl = col_ctrl;

   assign lane_load[0] = src.col;
   assign lane_load[1] = src.row;
   assign lane_ret[0]  = col_ret_nib;
   assign lane_ret[1]  = row_ret_nib;
   assign col_nib      = lane_nib[0];
   assign row_nib      = lane_nib[1];

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         systolic_host_link_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (blk_end),
            .load_data (lane_load[g]),
            .nib       (lane_nib[g]),
            .ret_nib   (lane_ret[g]),
            .rx_frame  (lane_rx[g])
         );
      end
   endgenerate
endmodule
